// File: rtl/ap_ctrl_pkg.sv
// Shared FSM encoding and default widths for the ap_ctrl_hs traffic driver.
package ap_ctrl_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int TXN_W_DEF = 16;
  localparam int DEPTH_DEF = 4;
  localparam int GAP_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/ap_ctrl_ts_fifo.sv
// Start-timestamp FIFO: one entry per accepted start still waiting for its done.
module ap_ctrl_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer bit tells full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_hs traffic driver: launches a run of starts and collects start-to-done latency.
// Define AP_CONTINUE_EN to drive ap_continue from sink_ready; otherwise ap_continue is tied high.
module ap_ctrl_driver
  import ap_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TXN_W = TXN_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [TXN_W-1:0] cfg_num_txn,
  input  logic [7:0]       cfg_gap,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  input  logic             sink_ready,
  output logic             busy,
  output logic             finish,
  output logic [TXN_W-1:0] txn_started,
  output logic [TXN_W-1:0] txn_done,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max,
  output logic [CNT_W-1:0] lat_sum,
  output logic             proto_err
);

  // state | meaning
  // IDLE  | waiting for a run command, statistics held
  // START | ap_start offered while timestamp FIFO has room
  // GAP   | idle spacing after an accepted start
  // DRAIN | all starts issued, waiting for the remaining dones
  state_t state, state_nxt;

  logic [CNT_W-1:0] cyc;
  logic [TXN_W-1:0] num_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] ts_head;
  logic [CNT_W-1:0] latency;
  logic [CNT_W:0]   sum_ext;
  logic fifo_full, fifo_empty;
  logic cfg_go, accept, done_evt, bypass, complete, orphan, last_txn;

`ifdef AP_CONTINUE_EN
  assign ap_continue = sink_ready;
`else
  logic sink_unused;
  assign sink_unused = sink_ready;
  assign ap_continue = 1'b1;
`endif

  assign cfg_go   = (state == IDLE) && cfg_valid;
  assign accept   = ap_start && ap_ready;
  assign done_evt = ap_done && ap_continue;
  assign bypass   = accept && done_evt && fifo_empty;
  assign complete = done_evt && (!fifo_empty || accept);
  assign orphan   = done_evt && fifo_empty && !accept;
  assign last_txn = ((txn_started + TXN_W'(1)) == num_q);
  // Subtraction wraps naturally, so a counter rollover mid-flight still gives the true latency.
  assign latency  = fifo_empty ? '0 : (cyc - ts_head);
  assign sum_ext  = {1'b0, lat_sum} + {1'b0, latency};
  assign busy     = (state != IDLE);

  ap_ctrl_ts_fifo #(
    .DEPTH (DEPTH),
    .W     (CNT_W)
  ) u_ts_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept && !bypass),
    .pop   (done_evt && !fifo_empty),
    .wdata (cyc),
    .rdata (ts_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cyc   <= '0;
    end else begin
      state <= state_nxt;
      cyc   <= cyc + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    ap_start  = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid && (cfg_num_txn != '0))
          state_nxt = START;
      end
      START: begin
        ap_start = !fifo_full;
        if (accept) begin
          if (last_txn)
            state_nxt = DRAIN;
          else if (gap_q != '0)
            state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1))
          state_nxt = START;
      end
      DRAIN: begin
        if (txn_done == num_q)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      num_q       <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      txn_started <= '0;
      txn_done    <= '0;
      lat_min     <= '1;
      lat_max     <= '0;
      lat_sum     <= '0;
      proto_err   <= 1'b0;
      finish      <= 1'b0;
    end else begin
      finish <= (cfg_go && (cfg_num_txn == '0)) || ((state == DRAIN) && (txn_done == num_q));
      if (cfg_go) begin
        num_q       <= cfg_num_txn;
        gap_q       <= cfg_gap;
        txn_started <= '0;
        txn_done    <= '0;
        lat_min     <= '1;
        lat_max     <= '0;
        lat_sum     <= '0;
        proto_err   <= 1'b0;
      end else begin
        if (accept) begin
          txn_started <= txn_started + TXN_W'(1);
          gap_cnt     <= gap_q;
        end else if (state == GAP) begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end
        if (complete) begin
          txn_done <= txn_done + TXN_W'(1);
          if (latency < lat_min)
            lat_min <= latency;
          if (latency > lat_max)
            lat_max <= latency;
          lat_sum <= sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
        end
        if (orphan)
          proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Directed bench for ap_ctrl_driver: behavioural ap_ctrl_hs responder plus a latency scoreboard.
`timescale 1ns/1ps
module tb_ap_ctrl_driver;

  localparam int CNT_W = 8;
  localparam int TXN_W = 8;
  localparam int DEPTH = 4;
  localparam int SAT   = 255;
`ifdef AP_CONTINUE_EN
  localparam int STALL_LAT = 7;
`else
  localparam int STALL_LAT = 4;
`endif

  typedef struct {
    int acc;
    int due;
  } txn_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [TXN_W-1:0] cfg_num_txn = '0;
  logic [7:0]       cfg_gap = '0;
  logic             ap_start;
  logic             ap_ready = 1'b0;
  logic             ap_done = 1'b0;
  logic             ap_continue;
  logic             sink_ready = 1'b1;
  logic             busy;
  logic             finish;
  logic [TXN_W-1:0] txn_started;
  logic [TXN_W-1:0] txn_done;
  logic [CNT_W-1:0] lat_min;
  logic [CNT_W-1:0] lat_max;
  logic [CNT_W-1:0] lat_sum;
  logic             proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  txn_t q[$];
  int tb_cyc = 0;
  int resp_lat = 0;
  int stall_left = 0;
  int exp_spacing = 0;
  int last_acc = -1;
  int max_out = 0;
  int n_finish = 0;
  int exp_done = 0;
  int exp_min = SAT;
  int exp_max = 0;
  int exp_sum = 0;
  bit rdy_en = 1'b0;
  bit rdy_alt = 1'b0;
  bit extra_done = 1'b0;
  bit resp_done = 1'b0;
  bit prev_cont = 1'b1;
  bit prev_start = 1'b0;
  bit prev_ready = 1'b0;

  ap_ctrl_driver #(
    .CNT_W (CNT_W),
    .TXN_W (TXN_W),
    .DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_num_txn (cfg_num_txn),
    .cfg_gap     (cfg_gap),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .sink_ready  (sink_ready),
    .busy        (busy),
    .finish      (finish),
    .txn_started (txn_started),
    .txn_done    (txn_done),
    .lat_min     (lat_min),
    .lat_max     (lat_max),
    .lat_sum     (lat_sum),
    .proto_err   (proto_err)
  );

  always #5 clock = ~clock;

  initial forever @(posedge clock) tb_cyc = tb_cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Responder: acts exactly on the falling edge, DUT samples on the following rising edge.
  initial begin
    txn_t t;
    int lat;
    forever begin
      @(negedge clock);
      if (finish)
        n_finish++;
      if (!sink_ready)
        check("ap_continue", ap_continue, prev_cont);
      if (resp_done && prev_cont && (q.size() > 0)) begin
        t = q.pop_front();
        lat = tb_cyc - t.acc;
        exp_done++;
        if (lat < exp_min) exp_min = lat;
        if (lat > exp_max) exp_max = lat;
        exp_sum = (exp_sum + lat > SAT) ? SAT : exp_sum + lat;
        check("sb_txn_done", txn_done, exp_done);
        check("sb_lat_min", lat_min, exp_min);
        check("sb_lat_max", lat_max, exp_max);
        check("sb_lat_sum", lat_sum, exp_sum);
      end
      if (busy && prev_start && !prev_ready)
        check("start_hold", ap_start, 1);
      if (q.size() >= DEPTH)
        check("full_gate", ap_start, 0);
      ap_ready = rdy_en && (!rdy_alt || ((tb_cyc % 2) == 1));
      if (ap_start && ap_ready) begin
        if ((exp_spacing > 0) && (last_acc >= 0))
          check("start_spacing", tb_cyc + 1 - last_acc, exp_spacing);
        last_acc = tb_cyc + 1;
        q.push_back('{acc: tb_cyc + 1, due: tb_cyc + 1 + resp_lat});
        if (q.size() > max_out)
          max_out = q.size();
      end
      resp_done = (q.size() > 0) && (q[0].due <= tb_cyc + 1);
      if (resp_done && (stall_left > 0)) begin
        sink_ready = 1'b0;
        stall_left--;
      end else begin
        sink_ready = 1'b1;
      end
`ifdef AP_CONTINUE_EN
      prev_cont = sink_ready;
`else
      prev_cont = 1'b1;
`endif
      ap_done    = resp_done || extra_done;
      prev_start = ap_start;
      prev_ready = ap_ready;
    end
  end

  task automatic chk_reset_state(input string tag);
    check({tag, "_ap_start"}, ap_start, 0);
    check({tag, "_finish"}, finish, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_txn_started"}, txn_started, 0);
    check({tag, "_txn_done"}, txn_done, 0);
    check({tag, "_lat_min"}, lat_min, SAT);
    check({tag, "_lat_max"}, lat_max, 0);
    check({tag, "_lat_sum"}, lat_sum, 0);
    check({tag, "_proto_err"}, proto_err, 0);
  endtask

  task automatic cfg_start(input int num, input int gap, input int lat, input bit rdy,
                           input bit alt, input int stall, input int spacing);
    resp_lat = lat;
    rdy_alt = alt;
    stall_left = stall;
    exp_spacing = spacing;
    last_acc = -1;
    max_out = 0;
    rdy_en = rdy;
    exp_done = 0;
    exp_min = SAT;
    exp_max = 0;
    exp_sum = 0;
    check("cfg_ready", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_num_txn = TXN_W'(num);
    cfg_gap = 8'(gap);
    step();
    cfg_valid = 1'b0;
    check("busy_after_cfg", busy, (num > 0) ? 1 : 0);
    check("proto_clr", proto_err, 0);
    check("txn_done_clr", txn_done, 0);
  endtask

  task automatic run(input int num, input int gap, input int lat, input bit alt,
                     input int stall, input int spacing);
    int f0;
    int t;
    f0 = n_finish;
    cfg_start(num, gap, lat, 1'b1, alt, stall, spacing);
    t = 0;
    while ((n_finish == f0) && (t < 2000)) begin
      step();
      t++;
    end
    check("finish_seen", n_finish - f0, 1);
    repeat (3) step();
    check("finish_once", n_finish - f0, 1);
    check("busy_end", busy, 0);
    check("cfg_ready_end", cfg_ready, 1);
    check("txn_started_end", txn_started, num);
    check("txn_done_end", txn_done, num);
    check("lat_min_end", lat_min, exp_min);
    check("lat_max_end", lat_max, exp_max);
    check("lat_sum_end", lat_sum, exp_sum);
  endtask

  task automatic apply_reset(input string tag);
    int f0;
    reset = 1'b0;
    q.delete();
    resp_done = 1'b0;
    ap_done = 1'b0;
    extra_done = 1'b0;
    stall_left = 0;
    rdy_en = 1'b0;
    ap_ready = 1'b0;
    #1;
    check({tag, "_start_now"}, ap_start, 0);
    check({tag, "_busy_now"}, busy, 0);
    f0 = n_finish;
    step();
    step();
    chk_reset_state(tag);
    reset = 1'b1;
    repeat (4) step();
    check({tag, "_no_finish"}, n_finish - f0, 0);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    step();
    step();
    chk_reset_state("por");
    reset = 1'b1;
    step();
    check("por_cfg_ready", cfg_ready, 1);

    // Done with nothing outstanding while idle.
    extra_done = 1'b1;
    step();
    extra_done = 1'b0;
    step();
    check("orphan_proto", proto_err, 1);
    check("orphan_txn_done", txn_done, 0);
    check("orphan_idle", busy, 0);

    run(0, 0, 0, 1'b0, 0, 0);
    check("zero_lat_min", lat_min, SAT);

    run(3, 0, 5, 1'b0, 0, 1);
    check("basic_min", lat_min, 5);
    check("basic_max", lat_max, 5);
    check("basic_sum", lat_sum, 15);

    run(3, 2, 1, 1'b0, 0, 3);
    check("gap_sum", lat_sum, 3);

    run(4, 1, 3, 1'b1, 0, 0);
    check("alt_sum", lat_sum, 12);

    run(8, 0, 10, 1'b0, 0, 0);
    check("pipe_max_out", max_out, DEPTH);
    check("pipe_min", lat_min, 10);
    check("pipe_max", lat_max, 10);
    check("pipe_sum", lat_sum, 80);

    run(6, 0, 50, 1'b0, 0, 0);
    check("sat_sum", lat_sum, SAT);
    check("sat_max", lat_max, 50);

    run(2, 0, 0, 1'b0, 0, 1);
    check("bypass_min", lat_min, 0);
    check("bypass_max", lat_max, 0);
    check("bypass_proto", proto_err, 0);

    run(1, 0, 4, 1'b0, 3, 0);
    check("stall_lat", lat_max, STALL_LAT);
    check("stall_sum", lat_sum, STALL_LAT);

    // Reset while ap_start is being held for a DUT that never becomes ready.
    cfg_start(2, 0, 5, 1'b0, 1'b0, 0, 0);
    step();
    step();
    check("hold_start", ap_start, 1);
    apply_reset("rst_start");

    // Reset while draining outstanding transactions.
    cfg_start(2, 0, 30, 1'b1, 1'b0, 0, 0);
    t = 0;
    while ((q.size() < 2) && (t < 50)) begin
      step();
      t++;
    end
    step();
    check("drain_started", txn_started, 2);
    check("drain_busy", busy, 1);
    apply_reset("rst_drain");

    run(3, 0, 5, 1'b0, 0, 1);
    check("post_rst_sum", lat_sum, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_driver.md
AP_CTRL_DRIVER -- requirements
Module: ap_ctrl_driver

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning cycle-counter and latency width.
REQ-002 SHALL have parameter TXN_W, default 16, meaning transaction-count width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning max outstanding transactions (timestamp FIFO depth, power of 2).
REQ-004 SHALL have port clock, input, 1, meaning the single clock, all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-006 SHALL have ports cfg_valid input 1 and cfg_ready output 1, meaning the run-command handshake.
REQ-007 SHALL have port cfg_num_txn, input, TXN_W, meaning transactions to launch.
REQ-008 SHALL have port cfg_gap, input, 8, meaning idle cycles between accepted starts.
REQ-009 SHALL have port ap_start, output, 1, meaning start to the DUT (ap_ctrl_hs).
REQ-010 SHALL have ports ap_ready input 1 and ap_done input 1, meaning DUT handshake returns.
REQ-011 SHALL have port ap_continue, output, 1, meaning DUT output acceptance.
REQ-012 SHALL have port sink_ready, input, 1, meaning downstream acceptance (used only under macro).
REQ-013 SHALL have ports busy output 1 and finish output 1, meaning run active, and one-cycle end-of-run pulse.
REQ-014 SHALL have ports txn_started and txn_done, output, TXN_W each, meaning run counters.
REQ-015 SHALL have ports lat_min, lat_max and lat_sum, output, CNT_W each, meaning latency statistics.
REQ-016 SHALL have port proto_err, output, 1, meaning sticky protocol-violation flag.

Function
REQ-017 SHALL implement FSM states IDLE, START, GAP and DRAIN; cfg_ready=1 only in IDLE; busy=1 outside IDLE.
REQ-018 SHALL, in IDLE on cfg_valid, latch cfg_num_txn/cfg_gap, clear counters, set lat_min to all-ones and lat_max/lat_sum/proto_err to 0.
REQ-019 SHALL, in IDLE on cfg_valid with cfg_num_txn=0, pulse finish the next cycle and stay in IDLE.
REQ-020 SHALL, in IDLE on cfg_valid with cfg_num_txn>0, go to START.
REQ-021 SHALL drive ap_start=1 in START only while the FIFO is not full, and hold it until ap_ready is sampled high.
REQ-022 SHALL treat ap_start&&ap_ready as acceptance: push the cycle counter into the FIFO and increment txn_started.
REQ-023 SHALL, after acceptance, go to DRAIN if txn_started reaches num_txn, else to GAP if gap>0, else stay in START.
REQ-024 SHALL hold ap_start=0 in GAP for exactly gap cycles, then return to START.
REQ-025 SHALL treat ap_done&&ap_continue as completion: pop the FIFO, increment txn_done and compute latency = cycle counter minus popped timestamp, modulo 2^CNT_W.
REQ-026 SHALL, on each completion, update lat_min and lat_max, and add the latency to lat_sum saturating at all-ones.
REQ-027 SHALL handle acceptance and completion in the same cycle with an empty FIFO by bypass, giving latency 0.
REQ-028 SHALL handle simultaneous push and pop on a non-empty FIFO with occupancy unchanged.
REQ-029 SHALL, on completion with an empty FIFO and no bypass, set proto_err, drop the event and leave the counters unchanged.
REQ-030 SHALL, in DRAIN, pulse finish one cycle after txn_done equals num_txn, then return to IDLE.
REQ-031 SHALL keep the free-running cycle counter wrapping at 2^CNT_W without error.
REQ-032 SHALL hold all statistics stable in IDLE until the next cfg_valid.

Reset
REQ-033 SHALL, on reset low, immediately force ap_start=0, finish=0, state IDLE, FIFO empty, counters 0, lat_min all-ones, proto_err 0 and cfg_ready=1 after release.
REQ-034 SHALL abandon any run when reset asserts mid-run, with no finish pulse.

Configuration
REQ-035 SHALL, with AP_CONTINUE_EN defined, drive ap_continue=sink_ready, so that ap_done while sink_ready=0 is not a completion.
REQ-036 SHALL, with AP_CONTINUE_EN undefined, tie ap_continue to 1 and leave sink_ready unused.

Structure
REQ-037 SHALL place the FSM state enum and default width constants in package ap_ctrl_pkg.
REQ-038 SHALL implement the timestamp FIFO as sub-module ap_ctrl_ts_fifo (DEPTH x CNT_W, with push, pop, full, empty).

Verification
REQ-039 SHALL cover num_txn=3, gap=0, DUT ready same cycle, done 5 cycles later -> txn_done=3, lat_min=lat_max=5, lat_sum=15, one finish pulse.
REQ-040 SHALL cover a pipelined DUT with DEPTH=4, ready every cycle, done after 10 -> ap_start drops while 4 are outstanding, and all latencies are 10.
REQ-041 SHALL cover ap_ready, ap_done and ap_start all high in one cycle with an empty FIFO -> latency 0 and proto_err=0.
REQ-042 SHALL cover ap_done pulsed in IDLE -> proto_err=1 and txn_done=0.
REQ-043 SHALL cover AP_CONTINUE_EN with sink_ready low for 3 cycles during done -> completion counted when sink_ready rises, and latency includes the 3 cycles.
REQ-044 SHALL cover reset asserted mid-DRAIN -> ap_start=0 immediately, no finish, and state IDLE after release.
